// File: rtl/cactus_sprite_renderer.sv
// Cactus sprite renderer: owns the scrolling cactus position, drives the sprite ROM address
// and emits per-pixel colour 3 cycles after the raster position. Optional `CACTUS_TRANSP_EN`.
module cactus_sprite_renderer #(
    parameter int          SPR_W      = 64,
    parameter int          SPR_H      = 32,
    parameter int          SCREEN_W   = 640,
    parameter int          Y_TOP      = 400,
    parameter int          START_X    = 640,
    parameter int          GAP_FRAMES = 30,
    parameter logic [15:0] TRANSP     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        frame_tick,
    input  logic        game_run,
    input  logic        restart,
    input  logic [3:0]  speed,
    output logic [11:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] pix_rgb,
    output logic        pix_valid,
    output logic [11:0] cactus_x,
    output logic        cactus_on
);
    localparam int CW = $clog2(SPR_W);
    localparam int GW = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;
    localparam logic signed [11:0] WRAP_X = 12'(-SPR_W);

    typedef enum logic [1:0] {IDLE, RUN, RESPAWN} state_t;

    state_t            state, state_nxt;
    logic signed [11:0] x, x_nxt, x_dec;
    logic [GW-1:0]     gap, gap_nxt;
    logic [1:0]        vld_pipe;

    assign x_dec = x - $signed({8'd0, speed});

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        gap_nxt   = gap;
        if (restart) begin
            state_nxt = RUN;
            x_nxt     = 12'(START_X);
            gap_nxt   = '0;
        end else if (game_run && frame_tick) begin
            case (state)
                IDLE: state_nxt = RUN;
                RUN: begin
                    if (x_dec <= WRAP_X) begin
                        state_nxt = RESPAWN;
                        x_nxt     = 12'(SCREEN_W);
                        gap_nxt   = '0;
                    end else begin
                        x_nxt = x_dec;
                    end
                end
                RESPAWN: begin
                    if (gap == GW'(GAP_FRAMES - 1)) begin
                        state_nxt = RUN;
                        x_nxt     = 12'(SCREEN_W);
                    end else begin
                        gap_nxt = gap + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Hit test in 13-bit signed so negative x cannot alias onto large columns.
    logic signed [12:0] hs, xs, xe;
    logic               h_in, v_in, in_box;
    logic [9:0]         dv;
    logic [CW-1:0]      col;
    logic [11:0]        addr_nxt;

    assign hs     = $signed({2'b00, hcount});
    assign xs     = $signed({x[11], x});
    assign xe     = xs + $signed(13'(SPR_W));
    assign h_in   = (hs >= xs) && (hs < xe);
    assign v_in   = (vcount >= 10'(Y_TOP)) && ({1'b0, vcount} < 11'(Y_TOP + SPR_H));
    assign in_box = (state == RUN) && h_in && v_in;
    assign dv     = vcount - 10'(Y_TOP);
    assign col    = hcount[CW-1:0] - x[CW-1:0];
    assign addr_nxt = in_box ? ((12'(dv) << CW) | 12'(col)) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= 12'(START_X);
            gap       <= '0;
            rom_addr  <= '0;
            vld_pipe  <= '0;
            pix_rgb   <= '0;
            pix_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            x        <= x_nxt;
            gap      <= gap_nxt;
            rom_addr <= addr_nxt;
            vld_pipe <= {vld_pipe[0], in_box};
`ifdef CACTUS_TRANSP_EN
            pix_valid <= vld_pipe[1] && (rom_data != TRANSP);
            pix_rgb   <= (vld_pipe[1] && (rom_data != TRANSP)) ? rom_data : '0;
`else
            pix_valid <= vld_pipe[1];
            pix_rgb   <= vld_pipe[1] ? rom_data : '0;
`endif
        end
    end

    assign cactus_x  = x;
    assign cactus_on = (state == RUN);
endmodule

// File: doc/cactus_sprite_renderer.md
Name: cactus_sprite_renderer

Overview:
- Sits directly downstream of the 64x32 RGB565 cactus sprite ROM.
- Consumes the raster position from the VGA timing block and generates the ROM read address.
- Compensates the ROM's 1-cycle registered read latency and emits a per-pixel cactus colour plus valid flag to the pixel mux.
- Owns the cactus horizontal position: scrolls left each frame, wraps, and respawns after a gap. The position is exported for collision logic.

Parameters:
- SPR_W, 64, sprite width in pixels; must be a power of two.
- SPR_H, 32, sprite height in pixels.
- SCREEN_W, 640, visible width; respawn x position.
- Y_TOP, 400, top row of the sprite, fixed ground line.
- START_X, 640, x loaded on reset/restart.
- GAP_FRAMES, 30, frames spent off-screen after a wrap before reappearing.
- TRANSP, 16'hFFFF, RGB565 colour key treated as transparent.

Ports:
- clk  in  1  system pixel clock
- rst_n  in  1  synchronous active-low reset
- hcount  in  11  current raster column
- vcount  in  10  current raster row
- frame_tick  in  1  one-cycle pulse at start of vblank
- game_run  in  1  high while game is in play
- restart  in  1  one-cycle pulse: reload START_X, enter RUN
- speed  in  4  pixels moved per frame
- rom_addr  out  12  sprite ROM address
- rom_data  in  16  ROM output, valid 1 cycle after rom_addr
- pix_rgb  out  16  cactus pixel colour
- pix_valid  out  1  cactus pixel opaque at this raster position
- cactus_x  out  12  signed left edge of cactus (two's complement)
- cactus_on  out  1  high when state is RUN

Behaviour:
- Reset: synchronous active-low reset, sampled on clk rising edge. On rst_n=0: state=IDLE, cactus_x=START_X, gap counter=0, rom_addr=0, pix_rgb=0, pix_valid=0, all pipeline valid bits=0, cactus_on=0.
- FSM states are IDLE, RUN and RESPAWN.
  - IDLE: x held. Go to RUN on restart, or on game_run=1 at a frame_tick.
  - RUN: on frame_tick with game_run=1, x <= x - speed (12-bit signed). If the new x <= -SPR_W: x <= SCREEN_W, gap counter <= 0, go to RESPAWN.
  - RESPAWN: cactus not drawn. Gap counter increments on each frame_tick while game_run=1. At GAP_FRAMES-1, go to RUN with x=SCREEN_W.
  - game_run=0 in any state: x and counters freeze; the state is held.
- Restart priority: restart has priority over frame_tick in the same cycle. It sets x=START_X and state=RUN, and clears the gap counter.
- Speed 0: x unchanged; no wrap.
- Hit test (stage 0, combinational on inputs): in_box = (state==RUN) & (signed hcount >= x) & (hcount < x+SPR_W) & (vcount >= Y_TOP) & (vcount < Y_TOP+SPR_H). Compare in 13-bit signed so that negative x and x near 2047 do not alias.
- Address: rom_addr <= (vcount-Y_TOP)*SPR_W + (hcount-x)[5:0], registered at the end of stage 0. When in_box=0, rom_addr <= 0. The in_box flag is registered alongside the address (v1).
- Stage 1: v2 <= v1. The ROM presents data for rom_addr during this stage.
- Stage 2: pix_rgb <= v2 ? rom_data : 0; pix_valid <= v2 (modified by the optional feature).
- Total latency: pix_rgb/pix_valid correspond to hcount/vcount presented exactly 3 cycles earlier. The VGA block delays its sync signals by 3 to match.
- Partial visibility: a partially off-screen cactus (x<0 or x>SCREEN_W-SPR_W) renders only its columns that fall on-screen. There is no wrap to the opposite edge.
- x updates only at frame_tick, so there is no mid-frame tearing.
- Reset mid-frame: the pipeline flushes and pix_valid=0 on the next cycle.
- Outputs: cactus_x is registered; cactus_on = (state==RUN).

Optional Feature:
- Macro: CACTUS_TRANSP_EN.
- Defined: at stage 2, pix_valid <= v2 & (rom_data != TRANSP); pix_rgb <= 0 when transparent.
- Undefined: every in-box pixel is valid, including TRANSP-coloured ones; the downstream mux handles keying.

Test Plan:
- Address and latency: reset, restart, x=100, speed=0. Present hcount=100, vcount=400 → rom_addr=0 next cycle. hcount=163, vcount=431 → rom_addr=2047. pix_valid asserts 3 cycles after the first in-box input; returned data matches the ROM model.
- Outside the box: hcount=99 or 164, vcount=399 or 432 → pix_valid=0, pix_rgb=0, rom_addr=0.
- Scroll, wrap and respawn: x=10, speed=5, game_run=1. The 15th frame_tick reaches x=-65 and wraps to 640; state=RESPAWN, cactus_on=0 for 30 frame_ticks, then RUN at x=640.
- Restart priority: restart and frame_tick in the same cycle with x=200, speed=4 → x=640, state=RUN, no decrement applied.
- Freeze: game_run=0 during RESPAWN with 10 ticks counted. 5 frame_ticks arrive → counter stays 10. Resume → respawn after 20 more ticks.
- Transparency, with CACTUS_TRANSP_EN: ROM word 16'hFFFF at an in-box pixel → pix_valid=0. 16'h07E0 → pix_valid=1, pix_rgb=16'h07E0. Without the macro, both give pix_valid=1.
